mac_sequencer: RTL and testbench
================================

// Module: mac_sequencer
// PURPOSE
//  Sequences one accumulating PE (pixel*coeff MAC, registered acc_out) through an N-tap dot product.
//  Issues tap addresses to pixel/coeff buffers (1-cycle read latency), drives PE enable/clear,
//  captures the final PE accumulator and returns it on a valid/ready result port.
//  Sits between the layer/window scheduler (start/cfg) and the PE plus its operand buffers.
// PARAMETERS
//  ACCUM_WIDTH  24  width of PE accumulator and result
//  MAX_TAPS     9   largest supported tap count (3x3 kernel)
//  ADDR_WIDTH   4   tap address width; must satisfy 2**ADDR_WIDTH >= MAX_TAPS
// PORTS
//  clk           in   1            single clock, rising edge
//  rst           in   1            asynchronous, active-high reset
//  start         in   1            begin a dot product; sampled only in IDLE
//  cfg_taps      in   ADDR_WIDTH+1 tap count, latched when start is accepted
//  abort         in   1            synchronous cancel of any operation in progress
//  busy          out  1            high in every state except IDLE
//  rd_en         out  1            read strobe to pixel and coeff buffers
//  rd_addr       out  ADDR_WIDTH   tap index, 0..taps-1
//  pe_enable     out  1            PE enable
//  pe_clear      out  1            PE clear (load product instead of accumulating)
//  pe_acc        in   ACCUM_WIDTH  PE acc_out
//  result        out  ACCUM_WIDTH  dot-product result, held stable while result_valid
//  result_valid  out  1            result available
//  result_ready  in   1            consumer accepts result
// BEHAVIOUR
//  - Reset: state IDLE; busy, rd_en, pe_enable, pe_clear, result_valid = 0; rd_addr = 0; result = 0.
//  - FSM: IDLE -> RUN -> DRAIN -> HOLD -> IDLE.
//    IDLE: on start, latch taps = clamp(cfg_taps, 0..MAX_TAPS); taps>0 -> RUN, taps==0 -> HOLD with result=0.
//    RUN: counter idx 0..taps-1; rd_en=1, rd_addr=idx each cycle. After idx==taps-1 -> DRAIN.
//    DRAIN: 2 cycles (buffer read + PE register), no reads. Last DRAIN cycle: result<=pe_acc, -> HOLD.
//    HOLD: result_valid=1; on result_valid&&result_ready -> IDLE (result_valid low next cycle).
//  - PE drive: pe_enable is rd_en delayed one cycle (a register); pe_clear is (idx==0 && rd_en) delayed one
//    cycle. No pe_enable outside these cycles, so the PE holds its value.
//  - Timing (start in cycle 0, taps=N): rd_en cycles 1..N; pe_enable cycles 2..N+1; pe_clear cycle 2 only;
//    pe_acc final in cycle N+2; result_valid first high in cycle N+3. Start-to-valid = N+3 cycles.
//  - Back-to-back: start accepted in the cycle after HOLD exits; start during busy is ignored (not queued).
//  - cfg_taps > MAX_TAPS clamps to MAX_TAPS; cfg_taps ignored outside the accept cycle.
//  - abort (any non-IDLE state): next cycle IDLE, rd_en/pe_enable/pe_clear/result_valid = 0,
//    result unchanged; abort wins over start and over result_ready in the same cycle; ignored in IDLE.
//  - Arithmetic: controller does none; result is pe_acc verbatim (PE wraps mod 2**ACCUM_WIDTH).
//  - Async rst mid-operation: all outputs return to reset values immediately; no residual pe_enable.
// TESTING
//  - N=9, buffer pixels=255, coeffs=255 -> one pe_clear, 9 pe_enable, result=585225, valid at cycle 12.
//  - N=4, pixels 1,2,3,4, coeffs 1 -> rd_addr 0,1,2,3 on cycles 1-4, result=10; N=1 pix 7 coeff 3 -> 21.
//  - result_ready low 5 cycles in HOLD with start pulsed -> result stable, busy=1, start ignored; ready=1 -> IDLE.
//  - cfg_taps=0 -> no rd_en/pe_enable, result=0 valid at cycle 1; cfg_taps=15 -> exactly 9 reads.
//  - abort in RUN at idx=3 -> next cycle IDLE, rd_en=0, no pe_enable after; new start N=2 gives correct sum.
//  - rst asserted mid-DRAIN -> all outputs 0 asynchronously; after release, a full N=9 run gives 585225.

Source files
------------

// File: rtl/mac_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mac_sequencer : walks one accumulating PE through an N-tap dot product and
//                 returns the final accumulator on a valid/ready result port.
// Revision 1.0
// ----------------------------------------------------------------------------
module mac_sequencer #(
  parameter int ACCUM_WIDTH = 24,
  parameter int MAX_TAPS    = 9,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    cfg_taps,
  input  logic                   abort,
  output logic                   busy,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   pe_enable,
  output logic                   pe_clear,
  input  logic [ACCUM_WIDTH-1:0] pe_acc,
  output logic [ACCUM_WIDTH-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ready
);

  localparam logic [ADDR_WIDTH:0]   C_MAX_TAPS = (ADDR_WIDTH+1)'(MAX_TAPS);
  localparam logic [ADDR_WIDTH:0]   C_TAP_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_IDX_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    idx_q, idx_d;
  logic [ADDR_WIDTH:0]      taps_q, taps_d;
  logic                     drain_q, drain_d;
  logic [ACCUM_WIDTH-1:0]   result_q, result_d;
  logic                     pe_enable_q, pe_enable_d;
  logic                     pe_clear_q, pe_clear_d;

  logic [ADDR_WIDTH:0]      w_taps_clamped;
  logic [ADDR_WIDTH:0]      w_taps_m1;
  logic                     w_last_tap;

  assign w_taps_clamped = (cfg_taps > C_MAX_TAPS) ? C_MAX_TAPS : cfg_taps;
  assign w_taps_m1      = taps_q - C_TAP_ONE;
  assign w_last_tap     = ({1'b0, idx_q} == w_taps_m1);

  assign busy         = (state_q != S_IDLE);
  assign rd_en        = (state_q == S_RUN);
  assign rd_addr      = idx_q;
  assign result_valid = (state_q == S_HOLD);
  assign result       = result_q;
  assign pe_enable    = pe_enable_q;
  assign pe_clear     = pe_clear_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    taps_d      = taps_q;
    drain_d     = drain_q;
    result_d    = result_q;
    // PE strobes trail the buffer read by one cycle to match its read latency
    pe_enable_d = rd_en && !abort;
    pe_clear_d  = rd_en && (idx_q == '0) && !abort;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          taps_d = w_taps_clamped;
          idx_d  = '0;
          if (w_taps_clamped == '0) begin
            result_d = '0;
            state_d  = S_HOLD;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_last_tap) begin
          idx_d   = '0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + C_IDX_ONE;
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          result_d = pe_acc;
          drain_d  = 1'b0;
          state_d  = S_HOLD;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel takes priority over every other transition, leaving result untouched
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      idx_d    = '0;
      drain_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      taps_q      <= '0;
      drain_q     <= 1'b0;
      result_q    <= '0;
      pe_enable_q <= 1'b0;
      pe_clear_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      taps_q      <= taps_d;
      drain_q     <= drain_d;
      result_q    <= result_d;
      pe_enable_q <= pe_enable_d;
      pe_clear_q  <= pe_clear_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mac_sequencer : directed bench with a behavioural PE and operand buffers.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mac_sequencer;

  localparam int ACCUM_WIDTH = 24;
  localparam int MAX_TAPS    = 9;
  localparam int ADDR_WIDTH  = 4;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic [ADDR_WIDTH:0]    cfg_taps;
  logic                   abort;
  logic                   busy;
  logic                   rd_en;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   pe_enable;
  logic                   pe_clear;
  logic [ACCUM_WIDTH-1:0] pe_acc;
  logic [ACCUM_WIDTH-1:0] result;
  logic                   result_valid;
  logic                   result_ready;

  mac_sequencer #(
    .ACCUM_WIDTH(ACCUM_WIDTH),
    .MAX_TAPS   (MAX_TAPS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_taps    (cfg_taps),
    .abort       (abort),
    .busy        (busy),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .pe_enable   (pe_enable),
    .pe_clear    (pe_clear),
    .pe_acc      (pe_acc),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffers (1-cycle read latency) and accumulating PE
  logic [7:0] pix_mem  [16];
  logic [7:0] coef_mem [16];
  logic [7:0] pix_q, coef_q;

  always @(posedge clk) begin
    if (rd_en) begin
      pix_q  <= pix_mem[rd_addr];
      coef_q <= coef_mem[rd_addr];
    end
    if (pe_enable) begin
      if (pe_clear) pe_acc <= ACCUM_WIDTH'(pix_q * coef_q);
      else          pe_acc <= pe_acc + ACCUM_WIDTH'(pix_q * coef_q);
    end
  end

  // Strobe counters and read-address log
  int         n_rd, n_en, n_clr;
  logic [3:0] addr_log [256];

  initial begin
    n_rd  = 0;
    n_en  = 0;
    n_clr = 0;
    pe_acc = '0;
    pix_q  = '0;
    coef_q = '0;
  end

  always @(posedge clk) begin
    if (rd_en) begin
      if (n_rd < 256) addr_log[n_rd] <= rd_addr;
      n_rd <= n_rd + 1;
    end
    if (pe_enable) n_en  <= n_en + 1;
    if (pe_clear)  n_clr <= n_clr + 1;
  end

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  task automatic fill(input int pix, input int coef);
    for (int i = 0; i < 16; i++) begin
      pix_mem[i]  = 8'(pix);
      coef_mem[i] = 8'(coef);
    end
  endtask

  // One full operation; hold_cycles keeps result_ready low in HOLD while start is pulsed
  task automatic run_op(input int n_cfg, input int exp_n, input logic [31:0] exp_res,
                        input int exp_lat, input int hold_cycles);
    int lat, rd0, en0, clr0;
    rd0  = n_rd;
    en0  = n_en;
    clr0 = n_clr;
    @(negedge clk);
    start    = 1'b1;
    cfg_taps = 5'(n_cfg);
    @(posedge clk); #1;
    start    = 1'b0;
    cfg_taps = 5'd3;
    lat = 1;
    while (!result_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("result", result, exp_res);
    for (int h = 0; h < hold_cycles; h++) begin
      start    = 1'b1;
      cfg_taps = 5'd4;
      @(posedge clk); #1;
      check("hold_result", result, exp_res);
      check("hold_busy", busy, 1);
      check("hold_valid", result_valid, 1);
    end
    start = 1'b0;
    check("rd_count", n_rd - rd0, exp_n);
    check("en_count", n_en - en0, exp_n);
    check("clr_count", n_clr - clr0, (exp_n > 0) ? 1 : 0);
    for (int i = 0; i < exp_n; i++) begin
      if (rd0 + i < 256) check("rd_addr", addr_log[rd0 + i], i);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("valid_drop", result_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int en0;
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    cfg_taps     = '0;
    abort        = 1'b0;
    result_ready = 1'b0;
    fill(255, 255);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_pe_en", pe_enable, 0);
    check("rst_pe_clr", pe_clear, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full kernel: 9 * 255 * 255
    run_op(9, 9, 585225, 12, 0);

    // N=4 with pixels 1..4, coeff 1
    fill(0, 1);
    for (int i = 0; i < 4; i++) pix_mem[i] = 8'(i + 1);
    run_op(4, 4, 10, 7, 0);

    // N=1, pix 7 * coeff 3, with consumer stalling 5 cycles while start is pulsed
    fill(7, 3);
    run_op(1, 1, 21, 4, 5);

    // Zero taps: immediate zero result, no reads
    run_op(0, 0, 0, 1, 0);

    // Oversized tap count clamps to 9
    fill(255, 255);
    for (int i = 9; i < 16; i++) pix_mem[i] = 8'd1;
    run_op(15, 9, 585225, 12, 0);

    // Abort in RUN at idx 3
    fill(255, 255);
    @(negedge clk);
    start    = 1'b1;
    cfg_taps = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_addr", rd_addr, 3);
    check("abort_rd_en", rd_en, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rd_en_off", rd_en, 0);
    check("abort_pe_en_off", pe_enable, 0);
    check("abort_result", result, 585225);
    en0 = n_en;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_pe_en", n_en - en0, 0);

    // Restart after abort: 3*5 + 4*6
    pix_mem[0] = 8'd3; coef_mem[0] = 8'd5;
    pix_mem[1] = 8'd4; coef_mem[1] = 8'd6;
    run_op(2, 2, 39, 5, 0);

    // Asynchronous reset in the first DRAIN cycle
    fill(255, 255);
    @(negedge clk);
    start    = 1'b1;
    cfg_taps = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("drain_busy", busy, 1);
    check("drain_rd_en", rd_en, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_pe_en", pe_enable, 0);
    check("arst_pe_clr", pe_clear, 0);
    check("arst_rd_en", rd_en, 0);
    check("arst_valid", result_valid, 0);
    check("arst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(9, 9, 585225, 12, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
